// File: rtl/calc_key_command_pkg.sv
// Shared constants and types for the calculator key-command front end.
package calc_key_command_pkg;

  localparam int KEY_ADD_EQ  = 3;
  localparam int KEY_SUB     = 2;
  localparam int KEY_MUL     = 1;
  localparam int KEY_DIV_CLR = 0;

  localparam logic MODE_CONTROL  = 1'b1;
  localparam logic MODE_OPERATOR = 1'b0;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  typedef struct packed {
    logic clear;
    logic equals;
    logic add;
    logic subtract;
    logic multiply;
    logic divide;
  } cmd_t;

  localparam cmd_t CMD_NONE = '0;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/calc_key_command_key_debounce.sv
// One pushbutton: 2-flop synchronizer, stability counter and debounced level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic debounced
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync;
  logic [CW-1:0] count;
  logic          level;

  // Counter holds the number of consecutive disagreeing samples already seen;
  // the level flips on the DEBOUNCE_CYCLES-th one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b1;
      sync      <= 1'b1;
      count     <= '0;
      level     <= 1'b1;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
      if (sync == level) begin
        count <= '0;
      end else if (count == LAST) begin
        level <= sync;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign debounced = level;

endmodule

// File: rtl/calc_key_command.sv
// Turns raw keys, mode switch and number switches into single-cycle commands
// with a captured operand; one decision per press episode.
module calc_key_command
  import calc_key_command_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_W           = 11
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [3:0]       KEY,
  input  logic             Mode,
  input  logic [NUM_W-1:0] SwNumber,
  output logic             Clear,
  output logic             Equals,
  output logic             Add,
  output logic             Subtract,
  output logic             Multiply,
  output logic             Divide,
  output logic [NUM_W-1:0] Number,
  output logic             MultiPress
);

  logic [3:0] debounced;
  logic [3:0] pressed;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk      (Clock),
        .rst_n    (Resetn),
        .raw      (KEY[gi]),
        .debounced(debounced[gi])
      );
    end
  endgenerate

  assign pressed = ~debounced;

  logic mode_meta;
  logic mode_sync;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      mode_meta <= 1'b0;
      mode_sync <= 1'b0;
    end else begin
      mode_meta <= Mode;
      mode_sync <= mode_meta;
    end
  end

  state_t           state, state_next;
  cmd_t             cmd_reg, cmd_next;
  cmd_t             decoded;
  logic             multi_reg, multi_next;
  logic [NUM_W-1:0] number_reg, number_next;
  logic [2:0]       press_count;

  assign press_count = popcount4(pressed);

  always_comb begin
    decoded = CMD_NONE;
    if (mode_sync == MODE_CONTROL) begin
      decoded.clear  = pressed[KEY_DIV_CLR];
      decoded.equals = pressed[KEY_ADD_EQ];
    end else begin
      decoded.add      = pressed[KEY_ADD_EQ];
      decoded.subtract = pressed[KEY_SUB];
      decoded.multiply = pressed[KEY_MUL];
      decoded.divide   = pressed[KEY_DIV_CLR];
    end
  end

  // Any press (even one that decodes to nothing) parks the FSM in HOLD
  // until every key is released, so later presses in the episode are ignored.
  always_comb begin
    state_next  = state;
    cmd_next    = CMD_NONE;
    multi_next  = 1'b0;
    number_next = number_reg;
    case (state)
      IDLE: begin
        if (press_count == 3'd1) begin
          cmd_next = decoded;
          if (decoded != CMD_NONE) begin
            number_next = SwNumber;
          end
          state_next = HOLD;
        end else if (press_count >= 3'd2) begin
          multi_next = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (pressed == 4'b0000) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      cmd_reg    <= CMD_NONE;
      multi_reg  <= 1'b0;
      number_reg <= '0;
    end else begin
      state      <= state_next;
      cmd_reg    <= cmd_next;
      multi_reg  <= multi_next;
      number_reg <= number_next;
    end
  end

  assign Clear      = cmd_reg.clear;
  assign Equals     = cmd_reg.equals;
  assign Add        = cmd_reg.add;
  assign Subtract   = cmd_reg.subtract;
  assign Multiply   = cmd_reg.multiply;
  assign Divide     = cmd_reg.divide;
  assign MultiPress = multi_reg;
  assign Number     = number_reg;

endmodule

// File: tb/tb_calc_key_command.sv
// Bench for calc_key_command: directed scenarios plus random key episodes
// checked against a press-episode level reference model.
module tb_calc_key_command;

  localparam int D   = 4;
  localparam int NW  = 11;
  localparam int SEG = 12;

  logic          Clock = 1'b0;
  logic          Resetn;
  logic [3:0]    KEY;
  logic          Mode;
  logic [NW-1:0] SwNumber;
  logic          Clear, Equals, Add, Subtract, Multiply, Divide, MultiPress;
  logic [NW-1:0] Number;
  logic [6:0]    obs_vec;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: whether a press episode is in progress, and last operand.
  bit            m_hold = 1'b0;
  logic [NW-1:0] m_num  = '0;

  calc_key_command #(
    .DEBOUNCE_CYCLES(D),
    .NUM_W          (NW)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .KEY       (KEY),
    .Mode      (Mode),
    .SwNumber  (SwNumber),
    .Clear     (Clear),
    .Equals    (Equals),
    .Add       (Add),
    .Subtract  (Subtract),
    .Multiply  (Multiply),
    .Divide    (Divide),
    .Number    (Number),
    .MultiPress(MultiPress)
  );

  always #5 Clock = ~Clock;

  assign obs_vec = {Clear, Equals, Add, Subtract, Multiply, Divide, MultiPress};

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic check7(input string tag, input logic [6:0] exp);
    vectors++;
    assert (obs_vec === exp) else begin
      miscompares++;
      $error("FAIL %s: outputs(clr,eq,add,sub,mul,div,multi)=%b expected=%b", tag, obs_vec, exp);
    end
  endtask

  task automatic check_num(input string tag, input logic [NW-1:0] exp);
    vectors++;
    assert (Number === exp) else begin
      miscompares++;
      $error("FAIL %s: Number=%0d expected=%0d", tag, Number, exp);
    end
  endtask

  function automatic logic [6:0] cmd_of(input logic mode, input int key);
    if (mode) begin
      case (key)
        0:       return 7'b1000000;
        3:       return 7'b0100000;
        default: return 7'b0000000;
      endcase
    end
    case (key)
      3:       return 7'b0010000;
      2:       return 7'b0001000;
      1:       return 7'b0000100;
      default: return 7'b0000010;
    endcase
  endfunction

  // One episode segment: all key changes on one edge, then SEG stable cycles.
  // The decision for the new key pattern is visible after edge D+3.
  task automatic run_seg(input string tag, input logic [3:0] press,
                         input logic mode, input logic [NW-1:0] num);
    logic [6:0] exp;
    int         pc;
    exp = 7'b0;
    pc  = $countones(press);
    if (!m_hold) begin
      if (pc == 1) begin
        for (int k = 0; k < 4; k++) if (press[k]) exp = cmd_of(mode, k);
        if (exp != 7'b0) m_num = num;
        m_hold = 1'b1;
      end else if (pc >= 2) begin
        exp    = 7'b0000001;
        m_hold = 1'b1;
      end
    end else if (pc == 0) begin
      m_hold = 1'b0;
    end
    KEY      = ~press;
    Mode     = mode;
    SwNumber = num;
    for (int c = 1; c <= SEG; c++) begin
      step();
      check7($sformatf("%s@%0d", tag, c), (c == D + 3) ? exp : 7'b0);
    end
    check_num({tag, "/num"}, m_num);
    $display("seg %-10s pressed=%b mode=%b sw=%0d expect=%b Number=%0d",
             tag, press, mode, num, exp, Number);
  endtask

  initial begin
    Resetn   = 1'b0;
    KEY      = 4'hF;
    Mode     = 1'b0;
    SwNumber = '0;
    repeat (2) @(negedge Clock);
    check7("reset_out", 7'b0);
    check_num("reset_num", '0);
    Resetn = 1'b1;
    run_seg("idle", 4'b0000, 1'b0, 11'd0);

    // Single Add press held long, then release
    run_seg("t1_add", 4'b1000, 1'b0, 11'd25);
    check_num("t1_num25", 11'd25);
    run_seg("t1_held", 4'b1000, 1'b0, 11'd25);
    run_seg("t1_rel", 4'b0000, 1'b0, 11'd25);

    // Short glitches on KEY0 must be filtered out
    for (int c = 0; c < 16; c++) begin
      KEY = ((c / 2) % 2 == 1) ? 4'hF : 4'hE;
      step();
      check7($sformatf("glitch@%0d", c), 7'b0);
    end
    KEY = 4'hF;
    for (int c = 0; c < 8; c++) begin
      step();
      check7($sformatf("glitch_tail@%0d", c), 7'b0);
    end
    check_num("glitch_num", m_num);
    $display("seg glitch     KEY0 toggled every 2 cycles, Number=%0d", Number);

    // Control mode, dead keys, operator mode
    run_seg("t3_clr", 4'b0001, 1'b1, 11'd300);
    run_seg("t3_rel1", 4'b0000, 1'b1, 11'd300);
    run_seg("t3_k1ctl", 4'b0010, 1'b1, 11'd5);
    run_seg("t3_rel2", 4'b0000, 1'b1, 11'd5);
    run_seg("t3_mul", 4'b0010, 1'b0, 11'd7);
    check_num("t3_num7", 11'd7);
    run_seg("t3_rel3", 4'b0000, 1'b0, 11'd7);

    // Simultaneous press
    run_seg("t4_multi", 4'b0110, 1'b0, 11'd55);
    run_seg("t4_rel", 4'b0000, 1'b0, 11'd55);
    run_seg("t4_sub", 4'b0100, 1'b0, 11'd66);
    run_seg("t4_rel2", 4'b0000, 1'b0, 11'd66);

    // Overlapping presses within one episode
    run_seg("t5_add", 4'b1000, 1'b0, 11'd10);
    run_seg("t5_both", 4'b1001, 1'b0, 11'd11);
    run_seg("t5_k0only", 4'b0001, 1'b0, 11'd12);
    run_seg("t5_rel", 4'b0000, 1'b0, 11'd12);
    run_seg("t5_div", 4'b0001, 1'b0, 11'd13);
    run_seg("t5_rel2", 4'b0000, 1'b0, 11'd13);

    // Mode flip while held only affects the next decision
    run_seg("m_add", 4'b1000, 1'b0, 11'd20);
    run_seg("m_flip", 4'b1000, 1'b1, 11'd21);
    run_seg("m_rel", 4'b0000, 1'b1, 11'd21);
    run_seg("m_eq", 4'b1000, 1'b1, 11'd22);
    run_seg("m_rel2", 4'b0000, 1'b1, 11'd22);

    // Random episodes
    for (int s = 0; s < 40; s++) begin
      logic [3:0] p;
      case ($urandom_range(0, 3))
        0:       p = 4'b0000;
        1:       p = 4'(1 << $urandom_range(0, 3));
        default: p = 4'($urandom_range(0, 15));
      endcase
      run_seg($sformatf("rnd%0d", s), p, 1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)));
    end
    run_seg("rnd_rel", 4'b0000, 1'b0, 11'd0);

    // Asynchronous reset during HOLD with the key still down
    run_seg("r_add", 4'b1000, 1'b0, 11'd1234);
    @(posedge Clock);
    #2 Resetn = 1'b0;
    #1;
    check7("rst_async_out", 7'b0);
    check_num("rst_async_num", '0);
    m_hold = 1'b0;
    m_num  = '0;
    @(negedge Clock);
    Resetn = 1'b1;
    run_seg("r_heldadd", 4'b1000, 1'b0, 11'd99);
    run_seg("r_rel", 4'b0000, 1'b0, 11'd99);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
